// File: rtl/operativo.sv
// Operativo datapath: X/H/S registers, 16-bit ALU and 8x8 shift-add multiplier.
// Define OPERATIVO_SAT_EN to saturate A+B at 16'hFFFF and A-B at 16'h0000.
module operativo #(
    parameter logic [15:0] K = 16'd3
) (
    input  logic        ck,
    input  logic        rst,
    input  logic [7:0]  x_in,
    input  logic        lx,
    input  logic [1:0]  m0,
    input  logic [1:0]  m1,
    input  logic [1:0]  m2,
    input  logic        h,
    input  logic        lh,
    input  logic        ls,
    output logic [15:0] s_out,
    output logic        pronto
);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t      r_state;
    state_t      w_state_n;

    logic [7:0]  r_x;
    logic [15:0] r_h;
    logic [15:0] r_s;
    logic [15:0] r_p;
    logic [1:0]  r_prev_m2;
    logic [2:0]  r_cnt;
    logic [15:0] r_mcand;
    logic [7:0]  r_mplier;
    logic [15:0] r_acc;

    logic [15:0] w_a;
    logic [15:0] w_b;
    logic [15:0] w_add;
    logic [15:0] w_sub;
    logic [15:0] w_r;
    logic [15:0] w_acc_n;
    logic        w_start;
    logic        w_last;
    logic        w_hold;

    always_comb begin
        w_a = 16'd0;
        case (m0)
            2'b00:   w_a = 16'd0;
            2'b01:   w_a = {8'b0, r_x};
            default: w_a = r_h;
        endcase
    end

    always_comb begin
        w_b = 16'd0;
        case (m1)
            2'b00:   w_b = {8'b0, r_x};
            2'b01:   w_b = K;
            2'b10:   w_b = r_h;
            default: w_b = 16'd0;
        endcase
    end

`ifdef OPERATIVO_SAT_EN
    logic [16:0] w_sum17;
    logic [16:0] w_dif17;

    assign w_sum17 = {1'b0, w_a} + {1'b0, w_b};
    assign w_dif17 = {1'b0, w_a} - {1'b0, w_b};
    assign w_add   = w_sum17[16] ? 16'hFFFF : w_sum17[15:0];
    assign w_sub   = w_dif17[16] ? 16'h0000 : w_dif17[15:0];
`else
    assign w_add = w_a + w_b;
    assign w_sub = w_a - w_b;
`endif

    always_comb begin
        w_r = 16'd0;
        case (m2)
            2'b00:   w_r = w_a;
            2'b01:   w_r = w_add;
            2'b10:   w_r = w_sub;
            default: w_r = r_p;
        endcase
    end

    assign w_start = (m2 == 2'b11) && (r_prev_m2 != 2'b11)
                     && (r_state == S_IDLE);
    assign w_last  = (r_cnt == 3'd7);
    // Loads that would capture a stale product are suppressed while busy.
    assign w_hold  = (m2 == 2'b11) && (r_state == S_BUSY);
    assign w_acc_n = r_acc + (r_mplier[0] ? r_mcand : 16'd0);

    always_ff @(posedge ck) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_n = S_BUSY;
            S_BUSY:  if (w_last)  w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            r_x       <= 8'd0;
            r_h       <= 16'd0;
            r_s       <= 16'd0;
            r_p       <= 16'd0;
            r_prev_m2 <= 2'b00;
            r_cnt     <= 3'd0;
            r_mcand   <= 16'd0;
            r_mplier  <= 8'd0;
            r_acc     <= 16'd0;
        end else begin
            r_prev_m2 <= m2;
            if (lx) begin
                r_x <= x_in;
            end
            if (lh && !(h && w_hold)) begin
                r_h <= h ? w_r : w_a;
            end
            if (ls && !w_hold) begin
                r_s <= w_r;
            end
            if (w_start) begin
                r_cnt    <= 3'd0;
                r_mcand  <= {8'b0, w_a[7:0]};
                r_mplier <= w_b[7:0];
                r_acc    <= 16'd0;
            end else if (r_state == S_BUSY) begin
                r_acc    <= w_acc_n;
                r_mcand  <= {r_mcand[14:0], 1'b0};
                r_mplier <= {1'b0, r_mplier[7:1]};
                r_cnt    <= r_cnt + 3'd1;
                if (w_last) begin
                    r_p <= w_acc_n;
                end
            end
        end
    end

    assign s_out  = r_s;
    assign pronto = (r_state == S_IDLE);

endmodule

// File: tb/tb_operativo.sv
// Directed bench for operativo: single-cycle vector table plus
// hand-written multiply, restart-while-busy and reset-mid-multiply sequences.
module tb_operativo;

    logic        ck;
    logic        rst;
    logic [7:0]  x_in;
    logic        lx;
    logic [1:0]  m0;
    logic [1:0]  m1;
    logic [1:0]  m2;
    logic        h;
    logic        lh;
    logic        ls;
    logic [15:0] s_out;
    logic        pronto;

    int checks;
    int errors;

    operativo #(.K(16'd3)) dut (
        .ck     (ck),
        .rst    (rst),
        .x_in   (x_in),
        .lx     (lx),
        .m0     (m0),
        .m1     (m1),
        .m2     (m2),
        .h      (h),
        .lh     (lh),
        .ls     (ls),
        .s_out  (s_out),
        .pronto (pronto)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    typedef struct {
        logic        lx;
        logic [7:0]  x;
        logic [1:0]  m0;
        logic [1:0]  m1;
        logic [1:0]  m2;
        logic        h;
        logic        lh;
        logic        ls;
        logic [15:0] es;
    } vec_t;

    vec_t tbl[24];

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic setin(input logic a_lx, input logic [7:0] a_x,
                         input logic [1:0] a_m0, input logic [1:0] a_m1,
                         input logic [1:0] a_m2, input logic a_h,
                         input logic a_lh, input logic a_ls);
        lx   = a_lx;
        x_in = a_x;
        m0   = a_m0;
        m1   = a_m1;
        m2   = a_m2;
        h    = a_h;
        lh   = a_lh;
        ls   = a_ls;
    endtask

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    // Steps until pronto rises (bounded); n counts edges taken, starting at n0.
    task automatic wait_done(input int n0, output int n);
        n = n0;
        for (int i = 0; i < 20; i++) begin
            step();
            n++;
            if (pronto === 1'b1) break;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [15:0] e_add;
        logic [15:0] e_sub;
`ifdef OPERATIVO_SAT_EN
        e_add = 16'hFFFF;
        e_sub = 16'h0000;
`else
        e_add = 16'h0002;
        e_sub = 16'hFFFD;
`endif
        checks = 0;
        errors = 0;

        tbl[0]  = '{1'b1, 8'd5,   2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[1]  = '{1'b0, 8'd0,   2'd1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b1, 16'd8};
        tbl[2]  = '{1'b1, 8'd9,   2'd1, 2'd3, 2'd1, 1'b0, 1'b0, 1'b1, 16'd5};
        tbl[3]  = '{1'b0, 8'd0,   2'd1, 2'd3, 2'd1, 1'b0, 1'b0, 1'b1, 16'd9};
        tbl[4]  = '{1'b0, 8'd0,   2'd1, 2'd1, 2'd2, 1'b0, 1'b0, 1'b1, 16'd6};
        tbl[5]  = '{1'b0, 8'd0,   2'd1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 16'd6};
        tbl[6]  = '{1'b0, 8'd0,   2'd2, 2'd2, 2'd1, 1'b0, 1'b0, 1'b1, 16'd18};
        tbl[7]  = '{1'b0, 8'd0,   2'd2, 2'd2, 2'd1, 1'b1, 1'b1, 1'b0, 16'd18};
        tbl[8]  = '{1'b0, 8'd0,   2'd3, 2'd1, 2'd2, 1'b0, 1'b0, 1'b1, 16'd15};
        tbl[9]  = '{1'b0, 8'd0,   2'd0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b1, 16'd0};
        tbl[10] = '{1'b1, 8'd255, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[11] = '{1'b0, 8'd0,   2'd1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 16'd0};
        for (int i = 12; i < 20; i++)
            tbl[i] = '{1'b0, 8'd0, 2'd2, 2'd2, 2'd1, 1'b1, 1'b1, 1'b0, 16'd0};
        tbl[20] = '{1'b0, 8'd0,   2'd2, 2'd0, 2'd1, 1'b1, 1'b1, 1'b0, 16'd0};
        tbl[21] = '{1'b0, 8'd0,   2'd2, 2'd1, 2'd1, 1'b0, 1'b0, 1'b1, e_add};
        tbl[22] = '{1'b0, 8'd0,   2'd0, 2'd1, 2'd2, 1'b0, 1'b0, 1'b1, e_sub};
        tbl[23] = '{1'b0, 8'd0,   2'd2, 2'd3, 2'd0, 1'b0, 1'b0, 1'b1, 16'hFFFF};

        rst = 1'b1;
        setin(1'b0, 8'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;
        chk("reset_s", s_out, 16'd0);
        chk("reset_pronto", {15'd0, pronto}, 16'd1);

        for (int i = 0; i < 24; i++) begin
            setin(tbl[i].lx, tbl[i].x, tbl[i].m0, tbl[i].m1, tbl[i].m2,
                  tbl[i].h, tbl[i].lh, tbl[i].ls);
            step();
            chk($sformatf("vec%0d_s", i), s_out, tbl[i].es);
            chk($sformatf("vec%0d_pronto", i), {15'd0, pronto}, 16'd1);
        end

        // Multiply 12*12 with blocked H/S loads while busy.
        rst = 1'b1;
        setin(1'b0, 8'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        setin(1'b1, 8'd12, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        setin(1'b0, 8'd0, 2'd1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        step();
        setin(1'b0, 8'd0, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        setin(1'b0, 8'd0, 2'd1, 2'd0, 2'd3, 1'b0, 1'b0, 1'b1);
        step();
        chk("mul12_start_pronto", {15'd0, pronto}, 16'd0);
        setin(1'b0, 8'd0, 2'd1, 2'd0, 2'd3, 1'b1, 1'b1, 1'b1);
        wait_done(0, n);
        chk("mul12_cycles", n[15:0], 16'd8);
        chk("mul12_s_blocked", s_out, 16'd0);
        setin(1'b0, 8'd0, 2'd1, 2'd0, 2'd3, 1'b0, 1'b0, 1'b1);
        step();
        chk("mul12_s", s_out, 16'd144);
        setin(1'b0, 8'd0, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        step();
        chk("mul12_h_kept", s_out, 16'd12);
        chk("mul12_no_restart", {15'd0, pronto}, 16'd1);

        // 8'hFF * 8'hFF, then a zero operand.
        setin(1'b1, 8'hFF, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        setin(1'b0, 8'd0, 2'd1, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0);
        step();
        wait_done(0, n);
        chk("mulff_cycles", n[15:0], 16'd8);
        setin(1'b0, 8'd0, 2'd1, 2'd0, 2'd3, 1'b0, 1'b0, 1'b1);
        step();
        chk("mulff_s", s_out, 16'hFE01);
        setin(1'b1, 8'd0, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        setin(1'b0, 8'd0, 2'd1, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0);
        step();
        wait_done(0, n);
        chk("mul0_cycles", n[15:0], 16'd8);
        setin(1'b0, 8'd0, 2'd1, 2'd0, 2'd3, 1'b0, 1'b0, 1'b1);
        step();
        chk("mul0_s", s_out, 16'd0);

        // Restart attempt on cycle 3 is ignored; 7*7 completes at N+8.
        setin(1'b1, 8'd7, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        setin(1'b0, 8'd0, 2'd1, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0);
        step();
        setin(1'b1, 8'd3, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        setin(1'b0, 8'd0, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        setin(1'b0, 8'd0, 2'd1, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0);
        step();
        chk("restart_busy", {15'd0, pronto}, 16'd0);
        wait_done(3, n);
        chk("restart_cycles", n[15:0], 16'd8);
        setin(1'b0, 8'd0, 2'd1, 2'd0, 2'd3, 1'b0, 1'b0, 1'b1);
        step();
        chk("restart_s", s_out, 16'd49);

        // Reset on cycle 4 of a 5*5 multiply, with competing loads.
        setin(1'b1, 8'd5, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        setin(1'b0, 8'd0, 2'd1, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0);
        step();
        setin(1'b0, 8'd0, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        step();
        rst = 1'b1;
        setin(1'b1, 8'd9, 2'd1, 2'd3, 2'd0, 1'b0, 1'b1, 1'b1);
        step();
        rst = 1'b0;
        chk("rstmul_pronto", {15'd0, pronto}, 16'd1);
        chk("rstmul_s", s_out, 16'd0);
        setin(1'b0, 8'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("rstmul_first_edge", {15'd0, pronto}, 16'd1);
        repeat (10) step();
        chk("rstmul_idle", {15'd0, pronto}, 16'd1);
        setin(1'b0, 8'd0, 2'd1, 2'd0, 2'd3, 1'b0, 1'b0, 1'b1);
        step();
        chk("rstmul_p_cleared", s_out, 16'd0);
        chk("rstmul_new_start", {15'd0, pronto}, 16'd0);
        setin(1'b0, 8'd0, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        wait_done(0, n);
        chk("rstmul_x0_cycles", n[15:0], 16'd8);
        setin(1'b0, 8'd0, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        step();
        chk("rstmul_h_cleared", s_out, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operativo.md
OPERATIVO -- requirements
Module: operativo

Interface
REQ-001 SHALL have parameter K, default 16'd3, constant operand selectable on operand B.
REQ-002 SHALL have port ck, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port x_in, input, 8, external operand sampled into X.
REQ-005 SHALL have port lx, input, 1, load X from x_in.
REQ-006 SHALL have port m0, input, 2, operand A select.
REQ-007 SHALL have port m1, input, 2, operand B select.
REQ-008 SHALL have port m2, input, 2, ALU operation select.
REQ-009 SHALL have port h, input, 1, H-register source select.
REQ-010 SHALL have port lh, input, 1, load H.
REQ-011 SHALL have port ls, input, 1, load S.
REQ-012 SHALL have port s_out, output, 16, contents of S.
REQ-013 SHALL have port pronto, output, 1, high when the multiplier is idle and P is valid.

Function
REQ-014 SHALL hold registers X[7:0], H[15:0], S[15:0] and product register P[15:0].
REQ-015 SHALL form operand A from m0: 00 -> 0; 01 -> {8'b0,X}; 10 and 11 -> H.
REQ-016 SHALL form operand B from m1: 00 -> {8'b0,X}; 01 -> K; 10 -> H; 11 -> 0.
REQ-017 SHALL compute ALU result R from m2: 00 -> A; 01 -> A+B; 10 -> A-B; 11 -> P; all arithmetic is 16-bit.
REQ-018 SHALL load X <= x_in on an edge with lx=1.
REQ-019 SHALL load H on an edge with lh=1: h=1 -> R, h=0 -> A.
REQ-020 SHALL load S <= R on an edge with ls=1.
REQ-021 SHALL drive s_out directly from S, with no added latency.
REQ-022 SHALL use the pre-edge register values for all operands, so simultaneous load and use sees the old value.
REQ-023 SHALL start a multiply on an edge where m2=11, the previous-cycle m2 is not 11, and the multiplier is idle.
REQ-024 SHALL, at the start edge, latch A[7:0] and B[7:0] and drive pronto low.
REQ-025 SHALL compute the product by iterative shift-add, one bit per cycle, over exactly 8 cycles.
REQ-026 SHALL, after start edge N, write P = A[7:0]*B[7:0] and raise pronto at edge N+8.
REQ-027 SHALL hold P unchanged while busy, so R for m2=11 returns the previous product until pronto rises.
REQ-028 SHALL ignore a start condition while busy (no restart, no queueing).
REQ-029 SHALL run a multiply to completion when m2 leaves 11 mid-operation.
REQ-030 SHALL treat a 0 operand normally: 8 cycles, P=0.
REQ-031 SHALL give 8'hFF*8'hFF P=16'hFE01 with no overflow.
REQ-032 SHALL ignore lh=1 with h=1 and m2=11 while pronto=0 (H unchanged), and likewise ls under the same condition.

Reset
REQ-033 SHALL, on an edge with rst=1, clear X, H, S and P to 0, set pronto=1, clear the previous-m2 register to 00, and abort any multiply.
REQ-034 SHALL give rst priority over every load and start on the same edge.
REQ-035 SHALL not start a multiply on the first edge after rst deasserts unless m2=11 on that edge (previous-m2 reads 00).

Configuration
REQ-036 SHALL, with OPERATIVO_SAT_EN defined, saturate A+B at 16'hFFFF and A-B at 16'h0000.
REQ-037 SHALL, without OPERATIVO_SAT_EN, wrap A+B and A-B modulo 2^16.
REQ-038 SHALL leave the multiplier and all other behaviour unaffected by OPERATIVO_SAT_EN.

Verification
REQ-039 SHALL cover load/add: rst; x_in=8'd5, lx -> X=5; m0=01, m1=01, m2=01, ls -> S=16'd8.
REQ-040 SHALL cover multiply: X=12, m0=01, m1=00, m2 00->11 -> pronto low 8 cycles; P=144; then m2=11, ls -> S=144.
REQ-041 SHALL cover wrap/saturate: H=16'hFFFF, m0=10, m1=01, m2=01, ls -> S=16'h0002 without the macro, 16'hFFFF with it; A=0, B=K, m2=10 -> 16'hFFFD or 16'h0000 respectively.
REQ-042 SHALL cover a restart while busy: second 00->11 transition on cycle 3 of a multiply -> ignored; pronto rises at N+8 with the first product.
REQ-043 SHALL cover reset mid-multiply: rst at cycle 4 -> pronto=1 next edge, P=0, S=0, no later P update.
REQ-044 SHALL cover load/use collision: lx with x_in=9 while m0=01, ls -> S takes the old X; next cycle uses 9.
